// File: rtl/pim_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// pim_cmd_sequencer
//
// Purpose:
//   Sits between the CPU's CFU command port and pim_model. Accepts one command
//   at a time over a valid/ready handshake and turns it into a single-cycle
//   pim_model access: word write, word read, or MAC over a row-wordline mask.
//   The mask is assembled from 32-bit chunks in an internal shadow register.
//   After the array latency the captured result is returned on a valid/ready
//   response channel.
//
// Opcodes (cmd_function_id):
//   0 WRITE      pim_addr = in0, pim_d = in1, pim_w_en pulse; response 0
//   1 READ       pim_addr = in0, no strobe; response pim_q
//   2 RWL_LOAD   shadow chunk in0 = in1 (local); response 0
//   3 MAC        pim_rwl = shadow, pim_p_en pulse; response pim_mac_out
//   4 RWL_CLEAR  shadow = 0 (local); response 0
//   5 STATS      counter read-back when PIM_SEQ_STATS_EN is defined, else illegal
//   6-7          illegal
//   Errors (bad address, bad chunk index, illegal opcode) answer 32'hFFFF_FFFF
//   without touching the array or the shadow.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   cmd_valid / cmd_ready      command handshake
//   cmd_function_id            3-bit opcode
//   cmd_inputs_0/1             32-bit operands
//   rsp_valid / rsp_ready      response handshake
//   rsp_outputs_0              32-bit response data, stable while rsp_valid
//   pim_d, pim_addr, pim_rwl   array data, word address, row-wordline mask
//   pim_w_en, pim_p_en         array write / MAC strobes (one cycle each)
//   pim_q, pim_mac_out         array read data and MAC result
//
// Configuration macro:
//   PIM_SEQ_STATS_EN  adds write/MAC issue counters readable through opcode 5.
// -----------------------------------------------------------------------------
module pim_cmd_sequencer #(
    parameter int DWIDTH  = 32,
    parameter int AWIDTH  = 8,
    parameter int PWIDTH  = 32,
    parameter int PDEPTH  = 256,
    parameter int PIM_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_function_id,
    input  logic [31:0]       cmd_inputs_0,
    input  logic [31:0]       cmd_inputs_1,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_outputs_0,
    output logic [PWIDTH-1:0] pim_d,
    output logic [AWIDTH-1:0] pim_addr,
    output logic [PDEPTH-1:0] pim_rwl,
    output logic              pim_w_en,
    output logic              pim_p_en,
    input  logic [PWIDTH-1:0] pim_q,
    input  logic [DWIDTH-1:0] pim_mac_out
);

    localparam int NCHUNK = PDEPTH / 32;
    // Wait counter holds PIM_LAT-1; keep it at least one bit wide.
    localparam int CW     = (PIM_LAT > 1) ? $clog2(PIM_LAT) : 1;

    typedef enum logic [2:0] {
        OP_WRITE     = 3'd0,
        OP_READ      = 3'd1,
        OP_RWL_LOAD  = 3'd2,
        OP_MAC       = 3'd3,
        OP_RWL_CLEAR = 3'd4,
        OP_STATS     = 3'd5,
        OP_ILL6      = 3'd6,
        OP_ILL7      = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_e;

    state_e              state_q;
    op_e                 op_q;
    logic                cmd_ready_q;
    logic                rsp_valid_q;
    logic [31:0]         rsp_data_q;
    logic [PWIDTH-1:0]   pim_d_q;
    logic [AWIDTH-1:0]   pim_addr_q;
    logic [PDEPTH-1:0]   pim_rwl_q;
    logic                pim_w_en_q;
    logic                pim_p_en_q;
    logic [PDEPTH-1:0]   shadow_q;
    logic [PDEPTH-1:0]   shadow_d;
    logic [CW-1:0]       wait_cnt_q;
`ifdef PIM_SEQ_STATS_EN
    logic [31:0]         write_cnt_q;
    logic [31:0]         mac_cnt_q;
`endif

    // Command decode, evaluated on the raw inputs in the accept cycle.
    op_e                 cmd_op;
    logic                accept;
    logic                addr_ok;
    logic                chunk_ok;
    logic                dec_pim;
    logic                dec_err;
    logic [31:0]         dec_rsp;

    assign cmd_op   = op_e'(cmd_function_id);
    // cmd_ready_q is only ever high in IDLE, so it alone qualifies the accept.
    assign accept   = cmd_valid & cmd_ready_q;
    assign addr_ok  = (cmd_inputs_0 >> AWIDTH) == 32'd0;
    assign chunk_ok = cmd_inputs_0 < 32'(NCHUNK);

    // NOTE: every variable driven here gets a default before the case so that
    // no path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        dec_pim = 1'b0;
        dec_err = 1'b0;
        dec_rsp = 32'd0;
        case (cmd_op)
            OP_WRITE,
            OP_READ: begin
                if (addr_ok) dec_pim = 1'b1;
                else         dec_err = 1'b1;
            end
            OP_RWL_LOAD: begin
                if (!chunk_ok) dec_err = 1'b1;
            end
            OP_MAC: begin
                dec_pim = 1'b1;
            end
            OP_RWL_CLEAR: begin
                dec_rsp = 32'd0;
            end
            OP_STATS: begin
`ifdef PIM_SEQ_STATS_EN
                dec_rsp = cmd_inputs_0[0] ? mac_cnt_q : write_cnt_q;
`else
                dec_err = 1'b1;
`endif
            end
            default: begin
                dec_err = 1'b1;
            end
        endcase
        if (dec_err) dec_rsp = 32'hFFFF_FFFF;
    end

    // Shadow mask next state: only legal RWL_LOAD / RWL_CLEAR accepts modify it.
    always_comb begin
        shadow_d = shadow_q;
        if (state_q == S_IDLE && accept && !dec_err) begin
            if (cmd_op == OP_RWL_LOAD) begin
                for (int c = 0; c < NCHUNK; c++) begin
                    if (cmd_inputs_0 == 32'(c)) shadow_d[c*32 +: 32] = cmd_inputs_1;
                end
            end else if (cmd_op == OP_RWL_CLEAR) begin
                shadow_d = '0;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments only, so every
    // right-hand side sees the pre-edge value regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            op_q        <= OP_WRITE;
            cmd_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 32'd0;
            pim_d_q     <= '0;
            pim_addr_q  <= '0;
            pim_rwl_q   <= '0;
            pim_w_en_q  <= 1'b0;
            pim_p_en_q  <= 1'b0;
            // NOTE: the shadow mask is a plain register, not a RAM, and must be
            // cleared by reset so a MAC after reset never drives a stale mask.
            shadow_q    <= '0;
            wait_cnt_q  <= '0;
`ifdef PIM_SEQ_STATS_EN
            write_cnt_q <= 32'd0;
            mac_cnt_q   <= 32'd0;
`endif
        end else begin
            shadow_q <= shadow_d;
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        op_q        <= cmd_op;
                        cmd_ready_q <= 1'b0;
                        if (dec_pim) begin
                            // Array outputs are loaded here so they are valid
                            // throughout the ISSUE cycle that follows.
                            state_q    <= S_ISSUE;
                            pim_w_en_q <= (cmd_op == OP_WRITE);
                            pim_p_en_q <= (cmd_op == OP_MAC);
                            if (cmd_op != OP_MAC) pim_addr_q <= AWIDTH'(cmd_inputs_0);
                            if (cmd_op == OP_WRITE) pim_d_q <= PWIDTH'(cmd_inputs_1);
                            if (cmd_op == OP_MAC) pim_rwl_q <= shadow_q;
                        end else begin
                            // Local and error ops answer straight away.
                            state_q     <= S_RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_data_q  <= dec_rsp;
                        end
                    end
                end
                S_ISSUE: begin
                    // Drop everything after one cycle; the mask in particular
                    // must not linger outside the MAC issue cycle.
                    pim_d_q    <= '0;
                    pim_addr_q <= '0;
                    pim_rwl_q  <= '0;
                    pim_w_en_q <= 1'b0;
                    pim_p_en_q <= 1'b0;
                    wait_cnt_q <= CW'(PIM_LAT - 1);
                    state_q    <= S_WAIT;
`ifdef PIM_SEQ_STATS_EN
                    if (op_q == OP_WRITE) write_cnt_q <= write_cnt_q + 32'd1;
                    if (op_q == OP_MAC)   mac_cnt_q   <= mac_cnt_q + 32'd1;
`endif
                end
                S_WAIT: begin
                    if (wait_cnt_q == '0) begin
                        case (op_q)
                            OP_READ: rsp_data_q <= 32'(pim_q);
                            OP_MAC:  rsp_data_q <= 32'(pim_mac_out);
                            default: rsp_data_q <= 32'd0;
                        endcase
                        rsp_valid_q <= 1'b1;
                        state_q     <= S_RESP;
                    end else begin
                        wait_cnt_q <= wait_cnt_q - CW'(1);
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready     = cmd_ready_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_outputs_0 = rsp_data_q;
    assign pim_d         = pim_d_q;
    assign pim_addr      = pim_addr_q;
    assign pim_rwl       = pim_rwl_q;
    assign pim_w_en      = pim_w_en_q;
    assign pim_p_en      = pim_p_en_q;

endmodule

// File: doc/pim_cmd_sequencer.md
# pim_cmd_sequencer

Command sequencer directly upstream of `pim_model` in the CFU path. It accepts one CFU command at a time from the CPU over a valid/ready handshake and translates it into a single-cycle `pim_model` access: word write, word read, or MAC over a 256-bit row-wordline mask. It assembles that mask from 32-bit chunks held in an internal shadow register, waits the array latency, and returns the captured result on a valid/ready response channel.

## Interface
Parameters:
- `DWIDTH`, 32, width of `pim_mac_out` and response data
- `AWIDTH`, 8, PIM word address width
- `PWIDTH`, 32, PIM data word width
- `PDEPTH`, 256, number of row wordlines; must be a multiple of 32
- `PIM_LAT`, 1, cycles from the `pim_model` issue edge until `pim_q`/`pim_mac_out` are valid; must be ≥1

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
- `clk`  in  1  clock
- `reset`  in  1  synchronous active-high reset
- `cmd_valid`  in  1  CPU command valid
- `cmd_ready`  out  1  sequencer can accept a command
- `cmd_function_id`  in  3  opcode
- `cmd_inputs_0`  in  32  operand 0 (address / chunk index / counter select)
- `cmd_inputs_1`  in  32  operand 1 (write data / mask chunk)
- `rsp_valid`  out  1  response valid
- `rsp_ready`  in  1  CPU accepts response
- `rsp_outputs_0`  out  32  response data
- `pim_d`  out  PWIDTH  write data to array
- `pim_addr`  out  AWIDTH  array word address
- `pim_rwl`  out  PDEPTH  row-wordline mask
- `pim_w_en`  out  1  write strobe
- `pim_p_en`  out  1  MAC strobe
- `pim_q`  in  PWIDTH  array read data
- `pim_mac_out`  in  DWIDTH  array MAC result

## Operation
- Opcodes:
  - 0 WRITE: `addr=in0`, `d=in1`, `w_en=1`. Response 0.
  - 1 READ: `addr=in0`, both strobes 0. Response `pim_q`.
  - 2 RWL_LOAD: `shadow[32*k+31:32*k] = in1`, where `k = in0`. Local op; response 0.
  - 3 MAC: `rwl = shadow`, `p_en=1`. Response `pim_mac_out`. The shadow is left unchanged.
  - 4 RWL_CLEAR: shadow = 0. Local op; response 0.
  - 5 STATS: see Configuration.
  - 6–7: illegal.
- Error conditions:
  - WRITE/READ with `in0[31:AWIDTH] != 0`.
  - RWL_LOAD with `in0 >= PDEPTH/32`.
  - Any illegal opcode.
  - Error response is 32'hFFFF_FFFF. No PIM strobe is issued and the shadow is unchanged.
- FSM states: IDLE, ISSUE, WAIT, RESP.
  - IDLE: `cmd_ready=1`. On accept (`cmd_valid & cmd_ready`):
    - PIM op → ISSUE.
    - Local or error op → RESP, with the response register loaded on the same edge.
  - ISSUE: drives `pim_*` for exactly one cycle. Next state WAIT, with the wait counter loaded to `PIM_LAT-1`.
  - WAIT: counts down. At 0, it captures `pim_q` (READ), `pim_mac_out` (MAC) or 0 (WRITE) into the response register, then → RESP.
  - RESP: `rsp_valid=1`; `rsp_outputs_0` is held stable. When `rsp_ready=1` → IDLE.
- Operand latching: operands are registered at accept, and the opcode is latched. `cmd_inputs_*` are don't-care after acceptance.
- `pim_rwl` is 0 in every cycle except the MAC ISSUE cycle. This prevents stray MAC activity.
- `pim_w_en` and `pim_p_en` are never high together.

## Timing
- Reset values:
  - State IDLE, `cmd_ready=1`, `rsp_valid=0`, `rsp_outputs_0=0`.
  - `pim_d=0`, `pim_addr=0`, `pim_rwl=0`, `pim_w_en=0`, `pim_p_en=0`.
  - Shadow 0; counters 0.
- Latency, with accept at edge E:
  - PIM op: strobes are high in the cycle after E. `rsp_valid` rises at edge E+1+PIM_LAT.
  - Local or error op: `rsp_valid` rises at E+1.
- Throughput: at most one command in flight. There is at least one IDLE cycle between the response handshake and the next accept, so `cmd_ready=0` in ISSUE, WAIT and RESP.
- `rsp_valid` remains high with stable data while `rsp_ready=0`, for any number of cycles.
- Reset in any state takes effect at the next edge:
  - State → IDLE, all outputs return to reset values, and strobes drop on that edge.
  - The in-flight command is dropped and no response is produced.

## Configuration
- `PIM_SEQ_STATS_EN` defined:
  - Two 32-bit counters, `write_cnt` and `mac_cnt`. Each increments in the ISSUE cycle of WRITE or MAC respectively, and wraps 0xFFFF_FFFF→0.
  - Opcode 5 returns `write_cnt` if `in0[0]=0`, or `mac_cnt` if `in0[0]=1`. It is a local op.
- `PIM_SEQ_STATS_EN` undefined: the counters are absent and opcode 5 is illegal (response 32'hFFFF_FFFF).

## Test plan
- Reset, then WRITE `in0=0x12`, `in1=0xA5A5_0001` → exactly one cycle with `pim_w_en=1`, `pim_addr=0x12`, `pim_d=0xA5A5_0001`; response 0 at E+2 (PIM_LAT=1).
- READ `in0=0x12` after the write → `rsp_outputs_0=0xA5A5_0001`. Hold `rsp_ready=0` for 5 cycles → `rsp_valid` and data stay stable and `cmd_ready=0`.
- RWL_LOAD k=0 with 0x0000_000F and k=7 with 0x8000_0000, then MAC → `pim_rwl` equals bit 255 plus bits 3:0 during ISSUE only, `pim_p_en` is high for one cycle, and the response equals `pim_mac_out`.
- Error cases, each responding 32'hFFFF_FFFF at E+1 with no strobe:
  - RWL_LOAD k=8.
  - READ `in0=0x100`.
  - Opcode 7.
- Assert reset during WAIT of a MAC → the next edge gives IDLE, strobes 0, `rsp_valid` never rises, and the shadow reads back as 0 (a following MAC drives `pim_rwl=0`).
- With `PIM_SEQ_STATS_EN`: 3 WRITEs and 2 MACs → opcode 5 `in0=0` returns 3 and `in0=1` returns 2. Without the macro, opcode 5 returns 32'hFFFF_FFFF.
